// File: rtl/temp_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_uart_pkg
// Description : Shared types and constants for the temperature UART
//               transmitter: FSM state encoding, data width, line idle level,
//               frame lengths for both build options, and a parity helper.
// Macro       : TEMP_UART_TX_PARITY_EN (selects which frame length applies)
// Revision    : 1.0 - initial release
// ============================================================================
package temp_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam int   FRAME_BITS_NO_PARITY = 10;
  localparam int   FRAME_BITS_PARITY    = 11;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temp_uart_baud.sv
`default_nettype none
// ============================================================================
// Module      : temp_uart_baud
// Description : Bit-period counter for the UART transmitter. Counts
//               0..CLKS_PER_BIT-1 and wraps; o_bit_end marks the last cycle
//               of each bit period.
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               i_clr     - synchronous clear, holds the count at 0
//               o_count   - current count within the bit period
//               o_bit_end - high while the count equals CLKS_PER_BIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module temp_uart_baud #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bit_end
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_bit_end = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/temp_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : temp_uart_tx
// Description : Sends the registered temperature byte as one UART frame:
//               start bit, 8 data bits LSB first, optional even parity bit,
//               stop bit. Single-cycle Send_T request, Busy_T while a frame
//               is in flight, one-cycle Done_T in the last stop-bit cycle.
// Ports       : Clk_T  - system clock
//               Rst_T  - synchronous active-high reset
//               Dato_T - byte to send, sampled on an accepted request
//               Send_T - transmit request, accepted only while idle
//               Busy_T - frame in progress
//               Done_T - last cycle of the stop bit
//               Tx_T   - serial line, idles high
// Macro       : TEMP_UART_TX_PARITY_EN - inserts the even parity bit
// Revision    : 1.0 - initial release
// ============================================================================
module temp_uart_tx
  import temp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 Clk_T,
  input  logic                 Rst_T,
  input  logic [DATA_BITS-1:0] Dato_T,
  input  logic                 Send_T,
  output logic                 Busy_T,
  output logic                 Done_T,
  output logic                 Tx_T
);

  localparam int                  c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam int                  c_idx_w    = $clog2(DATA_BITS);
  localparam logic [c_idx_w-1:0]  c_last_bit = c_idx_w'(DATA_BITS - 1);
  // Done is registered, so it is set one count before the final stop cycle.
  localparam logic [c_cnt_w-1:0]  c_done_pre = c_cnt_w'(CLKS_PER_BIT - 2);

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [c_idx_w-1:0]   w_bit_idx_next;
  logic [c_cnt_w-1:0]   w_count;
  logic                 w_bit_end;
  logic                 w_tx_next;
  logic                 w_done_next;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
`ifdef TEMP_UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Counter is held at zero while idle, so the start bit always begins at 0.
  temp_uart_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (c_cnt_w)
  ) u_baud (
    .clk       (Clk_T),
    .rst       (Rst_T),
    .i_clr     (r_state == IDLE),
    .o_count   (w_count),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge Clk_T) begin
    if (Rst_T) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != IDLE);
      r_done    <= w_done_next;
    end
  end

`ifdef TEMP_UART_TX_PARITY_EN
  always_ff @(posedge Clk_T) begin
    if (Rst_T) begin
      r_parity <= 1'b0;
    end else if (r_state == IDLE && Send_T) begin
      r_parity <= even_parity(Dato_T);
    end
  end
`endif

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (Send_T) begin
          w_state_next = START;
          w_shift_next = Dato_T;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == c_last_bit) begin
`ifdef TEMP_UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef TEMP_UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level is registered from the upcoming state so Tx_T lines up with
  // Busy_T on the edge after acceptance.
  always_comb begin
    w_tx_next = IDLE_LEVEL;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef TEMP_UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = IDLE_LEVEL;
    endcase
  end

  assign w_done_next = (r_state == STOP) && (w_count == c_done_pre);

  assign Tx_T   = r_tx;
  assign Busy_T = r_busy;
  assign Done_T = r_done;

endmodule
`default_nettype wire

// File: tb/tb_temp_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_uart_tx
// Description : Self-checking bench for temp_uart_tx with CLKS_PER_BIT=4.
//               Expected frames come from a vector table; accepted bytes are
//               queued and checked bit by bit as the line produces them.
// Macro       : TEMP_UART_TX_PARITY_EN - expects the parity bit when defined
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] dato;
  logic       send;
  logic       busy;
  logic       done;
  logic       tx;

  temp_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk_T  (clk),
    .Rst_T  (rst),
    .Dato_T (dato),
    .Send_T (send),
    .Busy_T (busy),
    .Done_T (done),
    .Tx_T   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame: line levels in transmit order, start bit first, stop bit last
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [0:9] frame;
  } vec_t;

  vec_t tbl [6];
  vec_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One-cycle request; input is released just after the sampling edge.
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    dato = d;
    send = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
  endtask

  task automatic recv_frame(input string nm, output int gap);
    vec_t       e;
    logic [0:10] bits;
    logic [3:0] samp;
    int         len;
    int         busy_n;
    int         done_n;
    int         done_pos;
    gap = 0;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      chk({nm, " start timeout"}, 32'(tx), 32'd0);
      return;
    end
    if (sb_q.size() == 0) begin
      chk({nm, " unexpected frame"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    for (int k = 0; k < 9; k++) bits[k] = e.frame[k];
`ifdef TEMP_UART_TX_PARITY_EN
    bits[9]  = e.par;
    bits[10] = 1'b1;
    len      = 11;
`else
    bits[9]  = e.frame[9];
    bits[10] = 1'b1;
    len      = 10;
`endif
    busy_n   = 0;
    done_n   = 0;
    done_pos = -1;
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        samp[c] = tx;
        if (busy === 1'b1) busy_n++;
        if (done === 1'b1) begin
          done_n++;
          done_pos = b * CPB + c;
        end
      end
      chk($sformatf("%s bit%0d", nm, b), 32'(samp), 32'({4{bits[b]}}));
    end
    chk({nm, " busy cycles"}, busy_n, len * CPB);
    chk({nm, " done count"}, done_n, 1);
    chk({nm, " done position"}, done_pos, len * CPB - 1);
    @(negedge clk);
    chk({nm, " idle tx"}, 32'(tx), 32'd1);
    chk({nm, " idle busy"}, 32'(busy), 32'd0);
    chk({nm, " idle done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int cnt;

    tbl[0] = '{8'hA5, 1'b0, 10'b0101001011};
    tbl[1] = '{8'h3C, 1'b0, 10'b0001111001};
    tbl[2] = '{8'h00, 1'b0, 10'b0000000001};
    tbl[3] = '{8'hFF, 1'b0, 10'b0111111111};
    tbl[4] = '{8'h07, 1'b1, 10'b0111000001};
    tbl[5] = '{8'h03, 1'b0, 10'b0110000001};

    // Reset held with a pending request: nothing may start.
    rst  = 1'b1;
    send = 1'b1;
    dato = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d tx", i), 32'(tx), 32'd1);
      chk($sformatf("reset%0d busy", i), 32'(busy), 32'd0);
      chk($sformatf("reset%0d done", i), 32'(done), 32'd0);
    end
    send = 1'b0;
    rst  = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) cnt++;
    end
    chk("post-reset no frame", cnt, 0);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(tbl[i]);
      send_byte(tbl[i].data);
      recv_frame($sformatf("vec%0d", i), gap);
      chk($sformatf("vec%0d latency", i), gap, 0);
    end

    // Request mid-frame with a different byte must be ignored.
    sb_q.push_back(tbl[1]);
    send_byte(tbl[1].data);
    fork
      recv_frame("ignored", gap);
      begin
        repeat (11) @(negedge clk);
        dato = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt++;
    end
    chk("ignored no second frame", cnt, 0);

    // Back-to-back: Send held high; byte changed after first acceptance.
    @(negedge clk);
    sb_q.push_back(tbl[2]);
    dato = 8'h00;
    send = 1'b1;
    fork
      begin
        recv_frame("b2b first", gap);
        recv_frame("b2b second", gap);
        chk("b2b gap", gap, 0);
      end
      begin
        repeat (3) @(negedge clk);
        dato = 8'hFF;
        sb_q.push_back(tbl[3]);
        repeat (50) @(negedge clk);
        send = 1'b0;
      end
    join
    chk("b2b queue drained", sb_q.size(), 0);

    // Reset during a frame aborts it without a done pulse.
    send_byte(8'hA5);
    repeat (20) @(negedge clk);
    chk("abort busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("abort no done", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
